// File: rtl/mult_div_seq_if.sv
// mult_div_seq_if: start/operand request and HI/LO result bundle for the mult/div unit
interface mult_div_seq_if #(parameter int WIDTH = 32);
  logic i_start;
  logic i_op;
  logic [WIDTH-1:0] i_src_a;
  logic [WIDTH-1:0] i_src_b;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic o_busy;
  logic o_done;
  logic o_div_zero;
  modport master (output i_start, i_op, i_src_a, i_src_b, input o_hi, o_lo, o_busy, o_done, o_div_zero);
  modport slave (input i_start, i_op, i_src_a, i_src_b, output o_hi, o_lo, o_busy, o_done, o_div_zero);
endinterface

// File: rtl/mult_div_seq.sv
// mult_div_seq: 32-iteration signed Booth multiply / restoring divide producing HI and LO
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  mult_div_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_op, r_dz, r_sa, r_sb, r_q1;
  logic [WIDTH:0] r_acc, w_bsum, w_sh, w_tr, w_acc;
  logic [WIDTH-1:0] r_x, r_m, r_hi, r_lo, w_x, w_q, w_r, w_ma, w_mb;
  logic w_ok, w_dz, w_last;
  assign w_dz = bus.i_op && bus.i_src_b == '0;
  assign w_ma = bus.i_src_a[WIDTH-1] ? -bus.i_src_a : bus.i_src_a;
  assign w_mb = bus.i_src_b[WIDTH-1] ? -bus.i_src_b : bus.i_src_b;
  assign w_last = r_cnt == CNT_W'(1);
  always_comb begin
    w_next = r_state == S_IDLE ? (bus.i_start ? (w_dz ? S_FIN : S_RUN) : S_IDLE) :
             r_state == S_RUN ? (w_last ? S_FIN : S_RUN) : S_IDLE;
  end
  // The accumulator carries one guard bit so Booth stays exact for the most negative multiplicand
  always_comb begin
    w_bsum = r_acc + ({r_x[0], r_q1} == 2'b01 ? {r_m[WIDTH-1], r_m} :
                      {r_x[0], r_q1} == 2'b10 ? -{r_m[WIDTH-1], r_m} : '0);
    w_sh = {r_acc[WIDTH-1:0], r_x[WIDTH-1]};
    w_tr = w_sh - {1'b0, r_m};
    w_ok = !w_tr[WIDTH];
    w_acc = r_op ? (w_ok ? w_tr : w_sh) : {w_bsum[WIDTH], w_bsum[WIDTH:1]};
    w_x = r_op ? {r_x[WIDTH-2:0], w_ok} : {w_bsum[0], r_x[WIDTH-1:1]};
    w_q = (r_sa ^ r_sb) ? -w_x : w_x;
    w_r = r_sa ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_hi, r_lo, r_acc, r_x, r_m} <= '0;
      {r_cnt, r_op, r_dz, r_sa, r_sb, r_q1} <= '0;
    end else if (r_state == S_IDLE && bus.i_start) begin
      r_op <= bus.i_op;
      r_dz <= w_dz;
      r_sa <= bus.i_src_a[WIDTH-1];
      r_sb <= bus.i_src_b[WIDTH-1];
      r_m <= bus.i_op ? w_mb : bus.i_src_a;
      r_x <= bus.i_op ? w_ma : bus.i_src_b;
      r_acc <= '0;
      r_q1 <= 1'b0;
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc;
      r_x <= w_x;
      r_q1 <= r_x[0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_hi <= r_op ? w_r : w_acc[WIDTH-1:0];
        r_lo <= r_op ? w_q : w_x;
      end
    end
  end
  assign bus.o_hi = r_hi;
  assign bus.o_lo = r_lo;
  assign bus.o_busy = r_state == S_RUN;
  assign bus.o_done = r_state == S_FIN;
  assign bus.o_div_zero = r_state == S_FIN && r_dz;
endmodule
